// File: rtl/uart_data_rx.sv
// rtl/uart_data_rx.sv - 8N1 UART receiver that packs bytes into DATA_WIDTH words with idle timeout
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_data_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx,
  input  logic [2:0]            baud_set,
  output logic                  rx_done,
  output logic                  timeout_flag,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nx;
  logic                  rx_meta, rx_sync, rx_prev;
  logic [12:0]           period, cnt, half;
  logic [2:0]            bit_cnt;
  logic [7:0]            rx_byte;
  logic [IW-1:0]         byte_idx, byte_pos;
  logic [DATA_WIDTH-1:0] shadow, shadow_nx;
  logic [16:0]           idle_cnt, idle_lim;
  logic                  start, sample, bit_val, bit_end, byte_ok, timeout;

  function automatic logic [12:0] baud_period(input logic [2:0] sel);
    case (sel)
      3'd0:    baud_period = 13'd5208;
      3'd1:    baud_period = 13'd2604;
      3'd2:    baud_period = 13'd1302;
      3'd3:    baud_period = 13'd868;
      default: baud_period = 13'd434;
    endcase
  endfunction

  assign start    = (state == IDLE) && rx_prev && !rx_sync;
  assign half     = {1'b0, period[12:1]};
  assign bit_end  = (cnt == period - 13'd1);
  assign idle_lim = ({4'd0, period} << 4) + ({4'd0, period} << 2);
  assign timeout  = (state == IDLE) && (byte_idx != '0) && (idle_cnt == idle_lim - 17'd1);
  assign byte_ok  = (state == STOP) && sample && bit_val;
  assign byte_pos = (MSB_FIRST != 0) ? IW'(NB - 1) - byte_idx : byte_idx;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // hist holds the line at the two clocks before the decision point
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist <= 2'b11;
    else          hist <= {hist[0], rx_sync};
  end

  assign sample  = (cnt == half + 13'd1);
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
`else
  assign sample  = (cnt == half);
  assign bit_val = rx_sync;
`endif

  always_comb begin
    shadow_nx = shadow;
    for (int i = 0; i < NB; i++) begin
      if (byte_pos == IW'(i)) shadow_nx[i*8 +: 8] = rx_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = START;
      START: begin
        if (sample && bit_val) state_nx = IDLE;
        else if (bit_end)      state_nx = DATA;
      end
      DATA:  if (bit_end && bit_cnt == 3'd7) state_nx = STOP;
      STOP:  if (sample) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      period       <= '0;
      cnt          <= '0;
      bit_cnt      <= '0;
      rx_byte      <= '0;
      byte_idx     <= '0;
      shadow       <= '0;
      idle_cnt     <= '0;
      data         <= '0;
      rx_done      <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      rx_meta      <= uart_rx;
      rx_sync      <= rx_meta;
      rx_prev      <= rx_sync;
      rx_done      <= 1'b0;
      timeout_flag <= 1'b0;

      // the detect clock counts as clock 0 of the start bit
      if (start)                         cnt <= 13'd1;
      else if (state == IDLE || bit_end) cnt <= '0;
      else                               cnt <= cnt + 13'd1;

      if (start) begin
        period  <= baud_period(baud_set);
        bit_cnt <= '0;
      end else if (state == DATA && bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (state == DATA && sample) rx_byte <= {bit_val, rx_byte[7:1]};

      if (start || state != IDLE || byte_idx == '0) idle_cnt <= '0;
      else                                          idle_cnt <= idle_cnt + 17'd1;

      // timeout wins over a coincident start: the new byte lands at index 0
      if (timeout) begin
        timeout_flag <= 1'b1;
        byte_idx     <= '0;
        shadow       <= '0;
      end else if (byte_ok) begin
        if (byte_idx == IW'(NB - 1)) begin
          data     <= shadow_nx;
          rx_done  <= 1'b1;
          byte_idx <= '0;
          shadow   <= '0;
        end else begin
          shadow   <= shadow_nx;
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_data_rx.sv
// tb/tb_uart_data_rx.sv - scoreboard bench for uart_data_rx, LSB-first and MSB-first instances on one line
module tb_uart_data_rx;

  localparam int BIT = 434;

  typedef struct {
    logic [31:0] w;
    longint      due;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        uart_rx;
  logic [2:0]  baud_set;
  logic        done_l, to_l, done_m, to_m;
  logic [31:0] data_l, data_m;

  longint cyc = 0;
  longint last_stop = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     n_to_m = 0;
  exp_t   q_l[$];
  exp_t   q_m[$];
  longint q_to[$];
  exp_t   el, em;
  longint due_to;
  logic [31:0] last_l = 0;
  logic [31:0] last_m = 0;

  uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .baud_set(baud_set),
    .rx_done(done_l), .timeout_flag(to_l), .data(data_l)
  );

  uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .baud_set(baud_set),
    .rx_done(done_m), .timeout_flag(to_m), .data(data_m)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit wobble);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (wobble && i == 3) baud_set = 3'd0;
      drive_bit(b[i]);
    end
    if (wobble) baud_set = 3'd4;
    last_stop = cyc;
    drive_bit(!bad_stop);
    if (bad_stop) drive_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input int bad_at, input int wob_at, input bit timed);
    exp_t e;
    e.w   = w;
    e.due = timed ? cyc + 39 * BIT + BIT / 2 + 4 : 0;
    q_l.push_back(e);
    e.w   = {w[7:0], w[15:8], w[23:16], w[31:24]};
    e.due = 0;
    q_m.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (k == bad_at) send_byte(8'h3C, 1'b1, 1'b0);
      send_byte(w[8*k +: 8], 1'b0, k == wob_at);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (done_l) begin
        if (q_l.size() == 0) check("lsb_extra_done", 1, 0);
        else begin
          el = q_l.pop_front();
          check("lsb_data", data_l, el.w);
          if (el.due != 0) check("lsb_done_time", (cyc >= el.due - 12) && (cyc <= el.due + 12), 1);
          last_l = el.w;
        end
      end
      if (done_m) begin
        if (q_m.size() == 0) check("msb_extra_done", 1, 0);
        else begin
          em = q_m.pop_front();
          check("msb_data", data_m, em.w);
          last_m = em.w;
        end
      end
      if (to_l) begin
        if (q_to.size() == 0) check("lsb_extra_timeout", 1, 0);
        else begin
          due_to = q_to.pop_front();
          check("lsb_timeout_time", (cyc >= due_to - 12) && (cyc <= due_to + 12), 1);
          check("lsb_timeout_data_kept", data_l, last_l);
        end
      end
      if (to_m) begin
        if (n_to_m == 0) check("msb_extra_timeout", 1, 0);
        else begin
          n_to_m--;
          check("msb_timeout_data_kept", data_m, last_m);
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    uart_rx  = 1'b1;
    baud_set = 3'd4;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data_lsb", data_l, 0);
    check("reset_data_msb", data_m, 0);
    check("reset_done", {done_l, done_m}, 0);
    check("reset_timeout", {to_l, to_m}, 0);
    @(posedge clk);
    reset_n = 1'b1;
    repeat (50) @(posedge clk);

    // back-to-back words, baud_set disturbed mid-frame in the second
    send_word(32'h12345678, -1, -1, 1'b1);
    send_word(32'h87654321, -1, 1, 1'b0);
    repeat (300) @(posedge clk);

    // partial word abandoned by idle timeout
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    q_to.push_back(last_stop + BIT / 2 + 20 * BIT + 4);
    n_to_m++;
    repeat (20 * BIT + 400) @(posedge clk);
    check("timeout_seen_lsb", q_to.size(), 0);
    check("timeout_seen_msb", n_to_m, 0);

    // reset in the middle of the second byte of a word
    send_byte(8'h5A, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_data_lsb", data_l, 0);
    check("midreset_data_msb", data_m, 0);
    check("midreset_flags", {done_l, done_m, to_l, to_m}, 0);
    last_l = 0;
    last_m = 0;
    uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);

    // fresh word with a corrupted-stop frame inserted before its third byte
    send_word(32'hCAFEF00D, 2, -1, 1'b0);
    repeat (600) @(posedge clk);

    check("lsb_words_pending", q_l.size(), 0);
    check("msb_words_pending", q_m.size(), 0);
    check("final_data_lsb", data_l, 32'hCAFEF00D);
    check("final_data_msb", data_m, 32'h0DF0FECA);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_data_rx.md
UART_DATA_RX -- requirements
Module: uart_data_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, received word width; a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter MSB_FIRST, default 0: 0 means first byte received goes to data[7:0]; 1 means first byte goes to data[DATA_WIDTH-1:DATA_WIDTH-8].
REQ-003 clk  input  1  single system clock, 50 MHz nominal; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 uart_rx  input  1  serial line; idle high; asynchronous to clk.
REQ-006 baud_set  input  3  baud select.
REQ-007 rx_done  output  1  one-cycle pulse: full word received.
REQ-008 timeout_flag  output  1  one-cycle pulse: partial word abandoned.
REQ-009 data  output  DATA_WIDTH  last complete received word.

Function
REQ-010 uart_rx SHALL pass through a 2-flop synchronizer; start = registered falling edge while the byte FSM is IDLE.
REQ-011 The bit period in clocks SHALL be set by baud_set: 0:5208 (9600), 1:2604 (19200), 2:1302 (38400), 3:868 (57600), 4:434 (115200), 5-7:434.
REQ-012 baud_set SHALL be latched at each start detection; changes mid-frame SHALL have no effect.
REQ-013 The byte FSM SHALL have states IDLE, START, DATA, STOP; each bit SHALL be sampled at bit-period/2 clocks into that bit.
REQ-014 If the start bit is high at its sample point, the FSM SHALL return to IDLE with no byte counted.
REQ-015 Frame format SHALL be 8N1: 8 data bits, LSB first, no parity, 1 stop bit.
REQ-016 A stop bit sampled low SHALL discard the byte; byte count unchanged; FSM returns to IDLE.
REQ-017 Valid bytes SHALL fill a shadow word in order per MSB_FIRST; byte index counts 0..DATA_WIDTH/8-1.
REQ-018 On the valid stop-bit sample of the last byte: data <= shadow word, rx_done = 1 for exactly one clock, byte index <= 0.
REQ-019 data SHALL hold its value until the next complete word; partial words SHALL never be visible on data.
REQ-020 While byte index > 0 and FSM IDLE, an idle counter SHALL count clocks; it SHALL clear on each start detection.
REQ-021 When the idle counter reaches 20 bit periods: timeout_flag = 1 for one clock, byte index <= 0, shadow word <= 0; data unchanged.
REQ-022 If timeout expiry and start detection coincide, timeout SHALL be processed first and the new byte SHALL become byte 0 of a new word.
REQ-023 No timeout SHALL fire while byte index = 0.
REQ-024 Back-to-back frames with zero idle time between stop and next start SHALL be received without loss.

Reset
REQ-025 While reset_n = 0: data = 0, rx_done = 0, timeout_flag = 0, FSM = IDLE, byte index = 0, all counters = 0, synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial word; after release, reception SHALL resume on the next falling edge.

Configuration
REQ-027 With macro UART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of samples at bit-period/2-1, /2 and /2+1 clocks into the bit.
REQ-028 Without UART_RX_MAJORITY_EN, each bit value SHALL be a single sample at bit-period/2; all other timing is identical.

Verification
REQ-029 baud_set=4, MSB_FIRST=0: send 32'h12345678 as bytes 78,56,34,12 -> one rx_done pulse about 40x434 clocks after the first start edge; data=32'h12345678.
REQ-030 Send 32'h87654321, then after 1 ms idle 32'h24680135 -> two rx_done pulses; data = each word in turn; timeout_flag never asserts.
REQ-031 Send bytes 0x11, 0x22, then idle -> timeout_flag pulses 20x434 clocks after the second stop sample; data keeps its prior value; the next 4 bytes form a fresh word.
REQ-032 Corrupt the stop bit of byte 2 to 0 -> that byte is dropped; the word completes only after 4 valid bytes.
REQ-033 MSB_FIRST=1, baud_set=0: send bytes 12,34,56,78 -> data=32'h12345678 with 5208-clock bit timing.
REQ-034 Assert reset_n low mid-byte -> all outputs 0 immediately; a following clean word is received correctly.
